// File: rtl/imm_ext_pkg.sv
// Shared constants for the pipelined immediate generator: format codes,
// instruction field positions and the MOV* halfword shift unit.
package imm_ext_pkg;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_D    = 3'd1;
    localparam logic [2:0] IMM_CBZ  = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_MOVZ = 3'd4;
    localparam logic [2:0] IMM_MOVK = 3'd5;
    localparam logic [2:0] IMM_MOVN = 3'd6;
    localparam logic [2:0] IMM_RSVD = 3'd7;

    localparam int I_MSB   = 21;
    localparam int I_LSB   = 10;
    localparam int D_MSB   = 20;
    localparam int D_LSB   = 12;
    localparam int CB_MSB  = 23;
    localparam int CB_LSB  = 5;
    localparam int B_MSB   = 25;
    localparam int B_LSB   = 0;
    localparam int F16_MSB = 20;
    localparam int F16_LSB = 5;
    localparam int HW_MSB  = 22;
    localparam int HW_LSB  = 21;
    localparam int HW_UNIT = 16;

    typedef struct packed {
        logic [25:0] imm;
        logic [5:0]  sh;
        logic [2:0]  ctrl;
        logic        illegal;
    } s1_t;

    function automatic logic is_mov(input logic [2:0] c);
        return (c == IMM_MOVZ) || (c == IMM_MOVK) || (c == IMM_MOVN);
    endfunction

    function automatic logic [5:0] hw_shift(input logic [1:0] hw);
        return 6'(32'(hw) * HW_UNIT);
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational format extension / MOVK merge, evaluated in stage 2.
// Illegal entries are forced to zero here so the output register needs no mux.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int SCALE_BRANCH = 1
) (
    input  logic [25:0]       imm26,
    input  logic [5:0]        sh,
    input  logic [2:0]        ctrl,
    input  logic              illegal,
    input  logic [DATA_W-1:0] merge_val,
    output logic [DATA_W-1:0] imm
);

    localparam int D_W  = D_MSB - D_LSB + 1;
    localparam int CB_W = CB_MSB - CB_LSB + 1;
    localparam int B_W  = B_MSB - B_LSB + 1;

    logic [DATA_W-1:0] field, movz, kmask, br, res;

    always_comb begin
        field = DATA_W'(imm26[F16_MSB:F16_LSB]);
        movz  = field << sh;
        kmask = DATA_W'(16'hFFFF) << sh;
        if (ctrl == IMM_CBZ)
            br = {{(DATA_W-CB_W){imm26[CB_MSB]}}, imm26[CB_MSB:CB_LSB]};
        else
            br = {{(DATA_W-B_W){imm26[B_MSB]}}, imm26[B_MSB:B_LSB]};
        // Scaling after extension; bits shifted past DATA_W are simply lost.
        if (SCALE_BRANCH != 0)
            br = br << 2;

        res = '0;
        case (ctrl)
            IMM_I:         res = DATA_W'(imm26[I_MSB:I_LSB]);
            IMM_D:         res = {{(DATA_W-D_W){imm26[D_MSB]}}, imm26[D_MSB:D_LSB]};
            IMM_CBZ,
            IMM_B:         res = br;
            IMM_MOVZ:      res = movz;
            IMM_MOVN:      res = ~movz;
            IMM_MOVK:      res = (merge_val & ~kmask) | movz;
            default:       res = '0;
        endcase
        if (illegal)
            res = '0;
    end

    assign imm = res;

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate generator with flush.
// IMM_EXTEND_MOVK_EN enables MOVK and the stage-1 merge_val register.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int SCALE_BRANCH = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [25:0]       imm26,
    input  logic [2:0]        ctrl,
    input  logic [DATA_W-1:0] merge_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] bus_imm,
    output logic [2:0]        out_ctrl,
    output logic              illegal
);

    logic [2:1]        vld_pipe;
    s1_t               s1_d, s1_q;
    logic [DATA_W-1:0] core_merge, core_imm;
    logic [1:0]        hw;
    logic              s2_take, acc, adv, dec_illegal;

    assign out_valid = vld_pipe[2];
    assign s2_take   = !vld_pipe[2] || out_ready;
    assign in_ready  = !vld_pipe[1] || s2_take;
    assign acc       = in_valid && in_ready;
    assign adv       = vld_pipe[1] && s2_take;
    assign hw        = imm26[HW_MSB:HW_LSB];

    always_comb begin
        dec_illegal = (ctrl == IMM_RSVD) || ((DATA_W == 32) && is_mov(ctrl) && hw[1]);
`ifndef IMM_EXTEND_MOVK_EN
        dec_illegal = dec_illegal || (ctrl == IMM_MOVK);
`endif
        s1_d = '{imm: imm26, sh: hw_shift(hw), ctrl: ctrl, illegal: dec_illegal};
    end

    // Flush only kills valids; payload registers keep their last contents.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            bus_imm  <= '0;
            out_ctrl <= '0;
            illegal  <= 1'b0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            if (s2_take)
                vld_pipe[2] <= vld_pipe[1];
            if (in_ready)
                vld_pipe[1] <= in_valid;
            if (acc)
                s1_q <= s1_d;
            if (adv) begin
                bus_imm  <= core_imm;
                out_ctrl <= s1_q.ctrl;
                illegal  <= s1_q.illegal;
            end
        end
    end

`ifdef IMM_EXTEND_MOVK_EN
    logic [DATA_W-1:0] s1_merge;

    always_ff @(posedge CLK) begin
        if (Reset)
            s1_merge <= '0;
        else if (!flush && acc)
            s1_merge <= merge_val;
    end

    assign core_merge = s1_merge;
`else
    logic unused_merge;

    assign unused_merge = ^merge_val;
    assign core_merge   = '0;
`endif

    imm_ext_core #(
        .DATA_W       (DATA_W),
        .SCALE_BRANCH (SCALE_BRANCH)
    ) u_core (
        .imm26     (s1_q.imm),
        .sh        (s1_q.sh),
        .ctrl      (s1_q.ctrl),
        .illegal   (s1_q.illegal),
        .merge_val (core_merge),
        .imm       (core_imm)
    );

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 64-bit scaled instance and a 32-bit unscaled
// instance share one stimulus stream and are scored against an arithmetic model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [25:0] imm26;
    logic [2:0]  ctrl;
    logic [63:0] merge;

    logic        rdy64, ov64, ill64, rdy32, ov32, ill32;
    logic [63:0] bus64;
    logic [31:0] bus32;
    logic [2:0]  oc64, oc32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.DATA_W(64), .SCALE_BRANCH(1)) dut (
        .CLK(clk), .Reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .imm26(imm26), .ctrl(ctrl), .merge_val(merge), .out_valid(ov64),
        .out_ready(out_ready), .bus_imm(bus64), .out_ctrl(oc64), .illegal(ill64)
    );

    imm_extend_pipe #(.DATA_W(32), .SCALE_BRANCH(0)) dut32 (
        .CLK(clk), .Reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .imm26(imm26), .ctrl(ctrl), .merge_val(merge[31:0]), .out_valid(ov32),
        .out_ready(out_ready), .bus_imm(bus32), .out_ctrl(oc32), .illegal(ill32)
    );

    typedef struct {
        logic [63:0] v64;
        logic [63:0] v32;
        logic        i64;
        logic        i32;
        logic [2:0]  c;
    } exp_t;

    typedef struct {
        logic [2:0]  c;
        logic [25:0] im;
        logic [63:0] mv;
        logic [63:0] e64;
        logic        i64;
        logic [31:0] e32;
        logic        i32;
    } vec_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: signed fields as integers, MOV* as halfword arithmetic.
    function automatic void model(input logic [2:0] c, input logic [25:0] im,
                                  input logic [63:0] mv, input int dw, input int scale,
                                  output logic [63:0] v, output logic il);
        longint          s;
        longint unsigned u, f16, pw, mask, old;
        int              hw;
        mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        hw   = int'(im[22:21]);
        f16  = longint'(im[20:5]);
        pw   = 64'd1 << (16 * hw);
        il   = 1'b0;
        u    = 0;
        case (c)
            3'd0: u = longint'(im[21:10]);
            3'd1: begin s = longint'(im[20:12]); if (s >= 256) s -= 512; u = s; end
            3'd2: begin
                s = longint'(im[23:5]); if (s >= 262144) s -= 524288;
                if (scale != 0) s = s * 4;
                u = s;
            end
            3'd3: begin
                s = longint'(im); if (s >= 33554432) s -= 67108864;
                if (scale != 0) s = s * 4;
                u = s;
            end
            3'd4, 3'd5, 3'd6: begin
                if (dw == 32 && hw >= 2) il = 1'b1;
                else if (c == 3'd4) u = f16 * pw;
                else if (c == 3'd6) u = ~(f16 * pw);
                else begin
`ifdef IMM_EXTEND_MOVK_EN
                    old = ((mv / pw) % 65536) * pw;
                    u   = mv - old + f16 * pw;
`else
                    old = mv;
                    il  = 1'b1;
`endif
                end
            end
            default: il = 1'b1;
        endcase
        if (il) u = 0;
        v = u & mask;
    endfunction

    // Scoreboard: check deliveries, then record accepted entries.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (ov64 && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", bus64);
                end else begin
                    e = q.pop_front();
                    chk("sb_bus64", bus64, e.v64);
                    chk("sb_ill64", 64'(ill64), 64'(e.i64));
                    chk("sb_ctrl64", 64'(oc64), 64'(e.c));
                    chk("sb_valid32", 64'(ov32), 64'd1);
                    chk("sb_bus32", 64'(bus32), e.v32);
                    chk("sb_ill32", 64'(ill32), 64'(e.i32));
                    chk("sb_ctrl32", 64'(oc32), 64'(e.c));
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && rdy64) begin
                model(ctrl, imm26, merge, 64, 1, e.v64, e.i64);
                model(ctrl, imm26, merge, 32, 0, e.v32, e.i32);
                e.c = ctrl;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk(name, 64'(q.size()), 64'd0);
    endtask

    initial begin
        vec_t        tbl[9];
        logic [25:0] sim[4];
        logic [2:0]  sc[4];
        int          idx, cyc;
        logic        acc;

        tbl[0] = '{3'd0, 26'h03F_FC00, 64'h0, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0};
        tbl[1] = '{3'd2, 26'h0FF_FFE0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFF, 1'b0};
`ifdef IMM_EXTEND_MOVK_EN
        tbl[2] = '{3'd5, 26'h057_DDE0, 64'h1111_2222_3333_4444, 64'h1111_BEEF_3333_4444, 1'b0, 32'h0, 1'b1};
`else
        tbl[2] = '{3'd5, 26'h057_DDE0, 64'h1111_2222_3333_4444, 64'h0, 1'b1, 32'h0, 1'b1};
`endif
        tbl[3] = '{3'd4, 26'h062_4680, 64'h0, 64'h1234_0000_0000_0000, 1'b0, 32'h0, 1'b1};
        tbl[4] = '{3'd3, 26'h200_0000, 64'h0, 64'hFFFF_FFFF_F800_0000, 1'b0, 32'hFE00_0000, 1'b0};
        tbl[5] = '{3'd1, 26'h010_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'hFFFF_FF00, 1'b0};
        tbl[6] = '{3'd6, 26'h000_1FE0, 64'h0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'hFFFF_FF00, 1'b0};
        tbl[7] = '{3'd7, 26'h3FF_FFFF, 64'h0, 64'h0, 1'b1, 32'h0, 1'b1};
        tbl[8] = '{3'd6, 26'h030_0000, 64'h0, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm26 = '0; ctrl = '0; merge = '0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(ov64), 64'd0);
        chk("rst_bus_imm", bus64, 64'd0);
        chk("rst_out_ctrl", 64'(oc64), 64'd0);
        chk("rst_illegal", 64'(ill64), 64'd0);
        chk("rst_in_ready", 64'(rdy64), 64'd1);
        tick();

        // Directed vectors, one at a time, checking two-cycle latency.
        for (int i = 0; i < 9; i++) begin
            ctrl = tbl[i].c; imm26 = tbl[i].im; merge = tbl[i].mv; in_valid = 1'b1;
            @(negedge clk);
            chk("tbl_accept", 64'(rdy64), 64'd1);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_lat1", 64'(ov64), 64'd0);
            tick();
            @(negedge clk);
            chk("tbl_lat2", 64'(ov64), 64'd1);
            chk("tbl_bus64", bus64, tbl[i].e64);
            chk("tbl_ill64", 64'(ill64), 64'(tbl[i].i64));
            chk("tbl_bus32", 64'(bus32), 64'(tbl[i].e32));
            chk("tbl_ill32", 64'(ill32), 64'(tbl[i].i32));
            tick();
        end
        drain("tbl_drain");

        // Four back-to-back entries with out_ready low for three cycles.
        for (int i = 0; i < 4; i++) begin
            sim[i] = 26'($urandom);
            sc[i]  = 3'($urandom_range(0, 6));
        end
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 50) begin
            in_valid  = 1'b1; imm26 = sim[idx]; ctrl = sc[idx];
            merge     = {$urandom, $urandom};
            out_ready = !(cyc >= 1 && cyc <= 3);
            @(negedge clk);
            acc = rdy64;
            if (cyc == 2) chk("stall_in_ready", 64'(rdy64), 64'd0);
            if (cyc == 3) chk("stall_out_valid", 64'(ov64), 64'd1);
            tick();
            if (acc) idx++;
            cyc++;
        end
        chk("stall_all_sent", 64'(idx), 64'd4);
        drain("stall_drain");

        // Flush with both stages full and an input waiting.
        out_ready = 1'b0; in_valid = 1'b1; ctrl = 3'd0; imm26 = 26'h000_0400;
        tick(); tick();
        @(negedge clk);
        chk("flush_full", 64'(rdy64), 64'd0);
        flush = 1'b1; imm26 = 26'h000_0800;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(ov64), 64'd0);
        chk("flush_in_ready", 64'(rdy64), 64'd1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        chk("flush_no_output", 64'(ov64), 64'd0);

        // Flush into an empty pipe: the presented input is dropped.
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("flush_drop", 64'(ov64), 64'd0);
        tick();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ctrl      = 3'($urandom);
            imm26     = 26'($urandom);
            merge     = {$urandom, $urandom};
            tick();
        end
        drain("rand_drain");

        // Reset mid-stream discards everything.
        out_ready = 1'b0; in_valid = 1'b1; ctrl = 3'd3; imm26 = 26'h000_0001;
        tick(); tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(ov64), 64'd0);
        chk("midrst_bus_imm", bus64, 64'd0);
        chk("midrst_in_ready", 64'(rdy64), 64'd1);
        out_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("midrst_no_output", 64'(ov64), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
